// File: rtl/ff_ce_sr_selftest_if.sv
// Signal bundle for the CE/SR flop bank: stimulus inputs, flop outputs,
// reductions and self-check status.
interface ff_ce_sr_selftest_if #(
    parameter int NUM_FF = 4,
    parameter int ERR_W  = 8
);
    logic              ce;
    logic              sr;
    logic              lfsr_en;
    logic              err_clr;
    logic [NUM_FF-1:0] d_ext;
    logic [NUM_FF-1:0] q_vcc_gnd;
    logic [NUM_FF-1:0] q_s_gnd;
    logic [NUM_FF-1:0] q_s_s;
    logic [NUM_FF-1:0] q_vcc_s;
    logic              xor_q;
    logic              or_q;
    logic              and_q;
    logic              chk_valid;
    logic              err_flag;
    logic [ERR_W-1:0]  err_cnt;

    modport master (
        output ce, sr, lfsr_en, err_clr, d_ext,
        input  q_vcc_gnd, q_s_gnd, q_s_s, q_vcc_s,
        input  xor_q, or_q, and_q, chk_valid, err_flag, err_cnt
    );

    modport slave (
        input  ce, sr, lfsr_en, err_clr, d_ext,
        output q_vcc_gnd, q_s_gnd, q_s_s, q_vcc_s,
        output xor_q, or_q, and_q, chk_valid, err_flag, err_cnt
    );
endinterface

// File: rtl/ff_ce_sr_selftest.sv
// Bank of NUM_FF channels, each with four CE/SR flop flavours, fed from
// external data or a Galois LFSR, with a shadow checker counting mis-mapped updates.
module ff_ce_sr_selftest_lane #(
    parameter logic INIT_BIT = 1'b0,
    parameter logic SRV      = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    input  logic ce,
    input  logic sr,
    output logic q_vcc_gnd,
    output logic q_s_gnd,
    output logic q_s_s,
    output logic q_vcc_s
);
    logic vg_d, vg_q, sg_d, sg_q, ss_d, ss_q, vs_d, vs_q;

    always_comb begin
        vg_d = d;
        sg_d = ce ? d : sg_q;
        ss_d = sr ? SRV : (ce ? d : ss_q);
        vs_d = sr ? SRV : d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vg_q <= INIT_BIT;
            sg_q <= INIT_BIT;
            ss_q <= INIT_BIT;
            vs_q <= INIT_BIT;
        end else begin
            vg_q <= vg_d;
            sg_q <= sg_d;
            ss_q <= ss_d;
            vs_q <= vs_d;
        end
    end

    assign q_vcc_gnd = vg_q;
    assign q_s_gnd   = sg_q;
    assign q_s_s     = ss_q;
    assign q_vcc_s   = vs_q;
endmodule

module ff_ce_sr_selftest #(
    parameter int          NUM_FF    = 4,
    parameter int          SR_SET    = 0,
    parameter int          INIT_VAL  = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          ERR_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    ff_ce_sr_selftest_if.slave bus
);
    localparam logic              SRV      = 1'(SR_SET);
    localparam logic              INIT_BIT = 1'(INIT_VAL);
    // An all-zero Galois state would lock up, so a zero seed is bumped to 1.
    localparam logic [15:0]       SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

    logic [15:0]         lfsr_d, lfsr_q;
    logic [NUM_FF-1:0]   d;
    logic [NUM_FF-1:0]   lane_vg, lane_sg, lane_ss, lane_vs;
    logic [NUM_FF-1:0]   q_vcc_gnd, q_s_gnd, q_s_s, q_vcc_s;
    logic [4*NUM_FF-1:0] all_q;

    always_comb begin
        lfsr_d = lfsr_q;
        if (bus.lfsr_en)
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= SEED;
        else        lfsr_q <= lfsr_d;
    end

    for (genvar i = 0; i < NUM_FF; i++) begin : g_lane
        assign d[i] = bus.lfsr_en ? lfsr_q[i % 16] : bus.d_ext[i];

        ff_ce_sr_selftest_lane #(.INIT_BIT(INIT_BIT), .SRV(SRV)) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .d         (d[i]),
            .ce        (bus.ce),
            .sr        (bus.sr),
            .q_vcc_gnd (lane_vg[i]),
            .q_s_gnd   (lane_sg[i]),
            .q_s_s     (lane_ss[i]),
            .q_vcc_s   (lane_vs[i])
        );
    end

    assign q_vcc_gnd = lane_vg;
    assign q_s_gnd   = lane_sg;
    assign q_s_s     = lane_ss;
    assign q_vcc_s   = lane_vs;

    assign all_q         = {q_vcc_gnd, q_s_gnd, q_s_s, q_vcc_s};
    assign bus.q_vcc_gnd = q_vcc_gnd;
    assign bus.q_s_gnd   = q_s_gnd;
    assign bus.q_s_s     = q_s_s;
    assign bus.q_vcc_s   = q_vcc_s;
    assign bus.xor_q     = ^all_q;
    assign bus.or_q      = |all_q;
    assign bus.and_q     = &all_q;

    // Shadow checker: replay last edge's inputs against last edge's outputs.
    logic [NUM_FF-1:0] d_prev_d, d_prev_q, vg_prev_d, vg_prev_q, sg_prev_d, sg_prev_q;
    logic [NUM_FF-1:0] ss_prev_d, ss_prev_q, vs_prev_d, vs_prev_q;
    logic [NUM_FF-1:0] exp_vg, exp_sg, exp_ss, exp_vs;
    logic              ce_prev_d, ce_prev_q, sr_prev_d, sr_prev_q;
    logic              chk_valid_d, chk_valid_q, err_flag_d, err_flag_q, mismatch;
    logic [ERR_W-1:0]  err_cnt_d, err_cnt_q;

    always_comb begin
        exp_vg      = d_prev_q;
        exp_sg      = ce_prev_q ? d_prev_q : sg_prev_q;
        exp_ss      = sr_prev_q ? {NUM_FF{SRV}} : (ce_prev_q ? d_prev_q : ss_prev_q);
        exp_vs      = sr_prev_q ? {NUM_FF{SRV}} : d_prev_q;
        mismatch    = chk_valid_q && ({exp_vg, exp_sg, exp_ss, exp_vs} != all_q);
        d_prev_d    = d;
        ce_prev_d   = bus.ce;
        sr_prev_d   = bus.sr;
        vg_prev_d   = q_vcc_gnd;
        sg_prev_d   = q_s_gnd;
        ss_prev_d   = q_s_s;
        vs_prev_d   = q_vcc_s;
        chk_valid_d = 1'b1;
        err_flag_d  = err_flag_q;
        err_cnt_d   = err_cnt_q;
        if (bus.err_clr) begin
            err_flag_d = 1'b0;
            err_cnt_d  = '0;
        end else if (mismatch) begin
            err_flag_d = 1'b1;
            if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_prev_q    <= '0;
            ce_prev_q   <= 1'b0;
            sr_prev_q   <= 1'b0;
            vg_prev_q   <= '0;
            sg_prev_q   <= '0;
            ss_prev_q   <= '0;
            vs_prev_q   <= '0;
            chk_valid_q <= 1'b0;
            err_flag_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            d_prev_q    <= d_prev_d;
            ce_prev_q   <= ce_prev_d;
            sr_prev_q   <= sr_prev_d;
            vg_prev_q   <= vg_prev_d;
            sg_prev_q   <= sg_prev_d;
            ss_prev_q   <= ss_prev_d;
            vs_prev_q   <= vs_prev_d;
            chk_valid_q <= chk_valid_d;
            err_flag_q  <= err_flag_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.chk_valid = chk_valid_q;
    assign bus.err_flag  = err_flag_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_ff_ce_sr_selftest.sv
// Randomised bench for two flop-bank configurations against a behavioural
// model of the flop flavours, LFSR and error accounting.
module tb_ff_ce_sr_selftest;
    localparam int NA = 4;
    localparam int NB = 20;

    logic        clk = 1'b0;
    logic        rst_n, ce, sr, lfsr_en, err_clr;
    logic [63:0] d_ext;
    logic [3:0]  fv_a;
    logic [19:0] fv_b;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    ff_ce_sr_selftest_if #(.NUM_FF(NA), .ERR_W(8)) ifa ();
    ff_ce_sr_selftest_if #(.NUM_FF(NB), .ERR_W(2)) ifb ();

    assign ifa.ce = ce;  assign ifa.sr = sr;  assign ifa.lfsr_en = lfsr_en;
    assign ifa.err_clr = err_clr;  assign ifa.d_ext = d_ext[NA-1:0];
    assign ifb.ce = ce;  assign ifb.sr = sr;  assign ifb.lfsr_en = lfsr_en;
    assign ifb.err_clr = err_clr;  assign ifb.d_ext = d_ext[NB-1:0];

    ff_ce_sr_selftest #(.NUM_FF(NA)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    ff_ce_sr_selftest #(.NUM_FF(NB), .SR_SET(1), .INIT_VAL(1), .LFSR_SEED(16'h0000), .ERR_W(2))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    // Model parameters per configuration: a = defaults, b = set-type, init 1, zero seed, 2-bit counter.
    int          nff  [2] = '{NA, NB};
    bit          srv  [2] = '{1'b0, 1'b1};
    bit          initv[2] = '{1'b0, 1'b1};
    logic [15:0] seed [2] = '{16'hACE1, 16'h0000};
    int          emax [2] = '{255, 3};

    logic [63:0] m_vg[2], m_sg[2], m_ss[2], m_vs[2], fv[2];
    logic [63:0] p_d[2], p_vg[2], p_sg[2], p_ss[2], p_vs[2];
    logic [15:0] m_lfsr[2];
    bit          p_ce[2], p_sr[2], m_armed[2], m_flag[2], frc[2];
    int          m_cnt[2];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] msk(input int k);
        return (64'd1 << nff[k]) - 64'd1;
    endfunction

    function automatic logic [63:0] din(input int k);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < nff[k]; i++)
            r[i] = lfsr_en ? m_lfsr[k][i % 16] : d_ext[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_vg[k] = initv[k] ? msk(k) : 64'd0;
            m_sg[k] = m_vg[k];  m_ss[k] = m_vg[k];  m_vs[k] = m_vg[k];
            m_lfsr[k] = (seed[k] == 16'h0) ? 16'h0001 : seed[k];
            m_armed[k] = 0;  m_flag[k] = 0;  m_cnt[k] = 0;
        end
    endtask

    task automatic model_edge(input int k);
        logic [63:0] d, sv, vss;
        bit          mis;
        d   = din(k);
        sv  = srv[k] ? msk(k) : 64'd0;
        vss = frc[k] ? fv[k] : m_ss[k];
        mis = 0;
        if (m_armed[k])
            mis = (m_vg[k] != p_d[k]) ||
                  (m_sg[k] != (p_ce[k] ? p_d[k] : p_sg[k])) ||
                  (vss     != (p_sr[k] ? sv : (p_ce[k] ? p_d[k] : p_ss[k]))) ||
                  (m_vs[k] != (p_sr[k] ? sv : p_d[k]));
        if (err_clr) begin
            m_cnt[k] = 0;  m_flag[k] = 0;
        end else if (mis) begin
            m_flag[k] = 1;
            if (m_cnt[k] < emax[k]) m_cnt[k]++;
        end
        p_d[k] = d;  p_ce[k] = ce;  p_sr[k] = sr;
        p_vg[k] = m_vg[k];  p_sg[k] = m_sg[k];  p_ss[k] = vss;  p_vs[k] = m_vs[k];
        m_armed[k] = 1;
        m_vg[k] = d;
        m_sg[k] = ce ? d : m_sg[k];
        m_ss[k] = sr ? sv : (ce ? d : m_ss[k]);
        m_vs[k] = sr ? sv : d;
        if (lfsr_en) m_lfsr[k] = (m_lfsr[k] >> 1) ^ ((m_lfsr[k] & 16'h1) != 0 ? 16'hB400 : 16'h0);
    endtask

    task automatic check_dut(input int k, input logic [63:0] vg, sg, ss, vs,
                             input logic x, o, a, cv, ef, input logic [63:0] ec);
        string p;
        p = (k == 0) ? "a." : "b.";
        chk({p, "q_vcc_gnd"}, vg, m_vg[k]);
        chk({p, "q_s_gnd"},   sg, m_sg[k]);
        chk({p, "q_s_s"},     ss, m_ss[k]);
        chk({p, "q_vcc_s"},   vs, m_vs[k]);
        chk({p, "xor_q"}, 64'(x), 64'(^(m_vg[k] ^ m_sg[k] ^ m_ss[k] ^ m_vs[k])));
        chk({p, "or_q"},  64'(o), 64'(|(m_vg[k] | m_sg[k] | m_ss[k] | m_vs[k])));
        chk({p, "and_q"}, 64'(a), 64'(m_vg[k] == msk(k) && m_sg[k] == msk(k) &&
                                      m_ss[k] == msk(k) && m_vs[k] == msk(k)));
        chk({p, "chk_valid"}, 64'(cv), 64'(m_armed[k]));
        chk({p, "err_flag"},  64'(ef), 64'(m_flag[k]));
        chk({p, "err_cnt"},   ec, 64'(m_cnt[k]));
    endtask

    task automatic check_all();
        check_dut(0, 64'(ifa.q_vcc_gnd), 64'(ifa.q_s_gnd), 64'(ifa.q_s_s), 64'(ifa.q_vcc_s),
                  ifa.xor_q, ifa.or_q, ifa.and_q, ifa.chk_valid, ifa.err_flag, 64'(ifa.err_cnt));
        check_dut(1, 64'(ifb.q_vcc_gnd), 64'(ifb.q_s_gnd), 64'(ifb.q_s_s), 64'(ifb.q_vcc_s),
                  ifb.xor_q, ifb.or_q, ifb.and_q, ifb.chk_valid, ifb.err_flag, 64'(ifb.err_cnt));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) begin model_edge(0); model_edge(1); end
        #1;
        check_all();
    endtask

    // One edge with q_s_s of the chosen bank(s) corrupted in bit 0 ahead of the edge.
    task automatic err_cycle(input bit fa, input bit fb, input bit clr);
        err_clr = clr;
        if (fa) begin
            fv_a = m_ss[0][NA-1:0] ^ 4'h1;  fv[0] = 64'(fv_a);  frc[0] = 1;
            force dut_a.q_s_s = fv_a;
        end
        if (fb) begin
            fv_b = m_ss[1][NB-1:0] ^ 20'h1;  fv[1] = 64'(fv_b);  frc[1] = 1;
            force dut_b.q_s_s = fv_b;
        end
        @(posedge clk);
        model_edge(0);  model_edge(1);
        #1;
        if (fa) release dut_a.q_s_s;
        if (fb) release dut_b.q_s_s;
        frc[0] = 0;  frc[1] = 0;  err_clr = 0;
        #1;
        check_all();
    endtask

    task automatic rand_in(input bit with_clr);
        ce      = 1'($urandom);
        sr      = ($urandom_range(0, 3) == 0);
        lfsr_en = 1'($urandom);
        d_ext   = {$urandom, $urandom};
        err_clr = with_clr && ($urandom_range(0, 7) == 0);
    endtask

    initial begin
        rst_n = 0;  ce = 0;  sr = 0;  lfsr_en = 0;  err_clr = 0;  d_ext = '0;
        frc[0] = 0;  frc[1] = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all();
        rst_n = 1;
        cycle();
        chk("a.armed_first_edge", 64'(ifa.chk_valid), 64'd1);

        // CE gating
        d_ext = '1;  ce = 0;  cycle();
        ce = 1;  cycle();
        chk("a.all_ones_and", 64'(ifa.and_q), 64'd1);

        // SR priority, then SR with CE low
        sr = 1;  cycle();
        ce = 0;  d_ext = '0;  cycle();
        chk("b.q_s_s_set", 64'(ifb.q_s_s), 64'hFFFFF);
        sr = 0;

        // LFSR drives data with random CE/SR, then holds while external data drives
        lfsr_en = 1;
        repeat (20) begin ce = 1'($urandom); sr = ($urandom_range(0, 3) == 0); cycle(); end
        lfsr_en = 0;
        repeat (4) begin d_ext = {$urandom, $urandom}; cycle(); end

        // Error path
        ce = 1;  sr = 0;
        err_cycle(1, 0, 0);
        chk("a.err_cnt_one", 64'(ifa.err_cnt), 64'd1);
        cycle();
        err_cycle(1, 0, 1);
        chk("a.err_clr_wins", 64'(ifa.err_cnt), 64'd0);
        repeat (5) err_cycle(0, 1, 0);
        chk("b.err_cnt_sat", 64'(ifb.err_cnt), 64'd3);
        err_clr = 1;  cycle();  err_clr = 0;

        // Async reset between edges
        repeat (5) begin rand_in(0); cycle(); end
        #2 rst_n = 0;
        #1 model_reset();
        check_all();
        chk("a.disarmed_no_edge", 64'(ifa.chk_valid), 64'd0);
        @(posedge clk);
        #1 check_all();
        rst_n = 1;
        cycle();  cycle();

        repeat (150) begin rand_in(1); cycle(); end
        err_clr = 0;
        repeat (3) begin ce = 1; sr = 0; err_cycle(1, 1, 0); cycle(); end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/ff_ce_sr_selftest.md
Name: ff_ce_sr_selftest

Overview:
- Parametrised bank of NUM_FF channels. Each channel has four D flip-flops, one per CE/SR flavour: vcc_gnd, s_gnd, s_s and vcc_s.
- Each channel is driven by either an external data bit or an internal LFSR.
- Combinational XOR/OR/AND reductions are taken over all flops.
- A shadow-model checker counts mapping mismatches.
- Used as the FPGA-side DUT for CE/SR packing and placement tests. It scales the fixed 4-flop pattern to arbitrary width and adds a self-check.

Parameters:
- NUM_FF, 4, number of channels (1..64).
- SR_SET, 0, sync SR value: 0 = clear (FDRE-like), 1 = set (FDSE-like).
- INIT_VAL, 0, value loaded into every flop on async reset.
- LFSR_SEED, 16'hACE1, LFSR reset value. Must be nonzero; a zero seed is forced to 16'h0001.
- ERR_W, 8, error counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable for the s_gnd and s_s flavours.
- sr  in  1  synchronous set/reset for the s_s and vcc_s flavours.
- lfsr_en  in  1  1 = LFSR drives data and the LFSR advances; 0 = d_ext drives data and the LFSR holds.
- d_ext  in  NUM_FF  external data, one bit per channel.
- err_clr  in  1  synchronous clear of err_cnt and err_flag.
- q_vcc_gnd  out  NUM_FF  CE tied 1, SR tied 0.
- q_s_gnd  out  NUM_FF  CE = ce, SR tied 0.
- q_s_s  out  NUM_FF  CE = ce, SR = sr.
- q_vcc_s  out  NUM_FF  CE tied 1, SR = sr.
- xor_q  out  1  XOR of all 4*NUM_FF flop outputs.
- or_q  out  1  OR of all 4*NUM_FF flop outputs.
- and_q  out  1  AND of all 4*NUM_FF flop outputs.
- chk_valid  out  1  checker armed.
- err_flag  out  1  sticky mismatch flag.
- err_cnt  out  ERR_W  saturating mismatch count.

Behaviour:
- rst_n low (async), all outputs:
  - All four q buses = {NUM_FF{INIT_VAL[0]}}.
  - LFSR = LFSR_SEED.
  - chk_valid = 0, err_flag = 0, err_cnt = 0.
  - Checker history registers = 0.
- Reset deassertion is sampled at the next rising edge with no other special handling.
- Data select, combinational: d[i] = lfsr_en ? lfsr[i % 16] : d_ext[i].
- LFSR: 16-bit Galois, mask 16'hB400, shifts right. Advances on each clk edge where lfsr_en=1; otherwise holds.
- Per-edge update of channel i, with srv = SR_SET:
  - vcc_gnd: q <= d[i].
  - s_gnd: q <= ce ? d[i] : q.
  - s_s: q <= sr ? srv : (ce ? d[i] : q). SR has priority over CE and applies even when ce=0.
  - vcc_s: q <= sr ? srv : d[i].
- Latency: one edge from d/ce/sr to q.
- Reductions are purely combinational on the q registers; no extra latency.
- Checker history:
  - Each edge registers d, ce, sr and all four q buses as *_prev.
  - chk_valid is set on the first edge after reset release and stays 1 until reset.
- Checker compare:
  - When chk_valid=1, each edge recomputes the expected value of all four flavours from the *_prev values using the update equations above.
  - Any bit differing from the current q counts as one mismatch event for that cycle, regardless of how many bits differ.
- Error accounting:
  - On a mismatch event: err_flag <= 1, and err_cnt increments, saturating at 2^ERR_W-1 with no wrap.
  - err_clr=1 at an edge: err_cnt <= 0 and err_flag <= 0. This takes priority over a mismatch in the same cycle.
- Reset asserted mid-run: everything returns immediately to reset values, and the checker is disarmed until the next edge after release.
- In correct silicon or RTL, err_cnt stays 0. Any nonzero value indicates a mis-mapped CE/SR.

Test Plan:
1. Reset and defaults, NUM_FF=4, INIT_VAL=0, lfsr_en=0: hold rst_n=0, then release -> all q=0, xor_q=0, or_q=0, and_q=0, chk_valid=1 after the first edge.
2. CE gating: ce=0, d_ext=4'hF, one edge -> q_vcc_gnd=F, q_vcc_s=F, q_s_gnd=0, q_s_s=0, or_q=1, and_q=0. Then ce=1, one edge -> all four buses =F, and_q=1, xor_q=0.
3. SR priority: d_ext=F, ce=1, sr=1 -> q_s_s=0, q_vcc_s=0, q_vcc_gnd=F, q_s_gnd=F. Then ce=0, sr=1, d=0 -> q_s_s=0, q_vcc_s=0, q_s_gnd holds F. Repeat with SR_SET=1 and d=0 -> q_s_s=F, q_vcc_s=F.
4. LFSR mode: lfsr_en=1, 20 edges -> q_vcc_gnd tracks lfsr[3:0] with one-edge lag. With lfsr_en=0 the LFSR holds. err_cnt=0 throughout with random ce/sr.
5. Error path: force q_s_s[0] for one cycle via a bench force -> err_flag=1, err_cnt=1. Then err_clr=1 coinciding with another forced mismatch -> err_cnt=0, err_flag=0. With ERR_W=2 and 5 consecutive forced mismatches -> err_cnt=3.
6. Async reset mid-run: drop rst_n between edges -> outputs reach reset values with no clock edge, chk_valid=0. Release rst_n -> operation resumes cleanly.
